// File: rtl/hazard_ctrl.sv
// Purpose  : stall/flush/bubble control for the 5-stage core (mem freeze > load-use > taken-branch flush).
// Latency  : controls are combinational from state and inputs (same cycle); state and counters are registered.
// Backpress: MemStall_i freezes the whole pipe; a branch seen while frozen is held as a pending flush.
//
// Ports:
//   clk_i, rst_i          core clock, synchronous active-high reset
//   MemStall_i            data cache busy, freeze everything
//   IDEX_MemRead_i/Rd_i   load in EX and its destination register
//   IFID_Rs1_i/Rs2_i      source registers of the instruction in ID
//   BranchTaken_i         branch in ID resolved taken
//   PCWrite_o, IFID_Stall_o, IFID_Flush_o, IDEX_Bubble_o, PipeStall_o   pipeline controls
//   StallCnt_o, FlushCnt_o                                             saturating perf counters
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             MemStall_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_Rd_i,
  input  logic [4:0]       IFID_Rs1_i,
  input  logic [4:0]       IFID_Rs2_i,
  input  logic             BranchTaken_i,
  output logic             PCWrite_o,
  output logic             IFID_Stall_o,
  output logic             IFID_Flush_o,
  output logic             IDEX_Bubble_o,
  output logic             PipeStall_o,
  output logic [CNT_W-1:0] StallCnt_o,
  output logic [CNT_W-1:0] FlushCnt_o
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_MSTALL = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_next_state;
  logic             r_flush_pend;
  logic             w_next_pend;
  logic             w_lu;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // x0 is hard-wired zero, so a load targeting it can never feed a consumer.
  assign w_lu = IDEX_MemRead_i && (IDEX_Rd_i != 5'd0) &&
                ((IDEX_Rd_i == IFID_Rs1_i) || (IDEX_Rd_i == IFID_Rs2_i));

  always_comb begin
    PCWrite_o     = 1'b0;
    IFID_Stall_o  = 1'b0;
    IFID_Flush_o  = 1'b0;
    IDEX_Bubble_o = 1'b0;
    PipeStall_o   = 1'b0;
    w_next_state  = r_state;
    w_next_pend   = r_flush_pend;

    if (!rst_i) begin
      // RUN and MSTALL share the same control decode: MSTALL only marks that
      // a freeze episode is in progress, the release cycle decodes like RUN.
      case (r_state)
        ST_RUN, ST_MSTALL: begin
          if (MemStall_i) begin
            PipeStall_o  = 1'b1;
            IFID_Stall_o = 1'b1;
            // Remember the branch; the flush is issued once the pipe moves.
            w_next_pend  = r_flush_pend | BranchTaken_i;
            w_next_state = ST_MSTALL;
          end else begin
            w_next_state = ST_RUN;
            if (w_lu) begin
              // Branch operands are stale while the load is outstanding, so
              // BranchTaken_i is ignored here; any older pending flush is kept.
              IFID_Stall_o  = 1'b1;
              IDEX_Bubble_o = 1'b1;
            end else if (BranchTaken_i || r_flush_pend) begin
              // A held branch plus a pending flush collapses into one flush.
              IFID_Flush_o = 1'b1;
              PCWrite_o    = 1'b1;
              w_next_pend  = 1'b0;
            end else begin
              PCWrite_o = 1'b1;
            end
          end
        end
        default: begin
          w_next_state = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_RUN;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_flush_pend <= w_next_pend;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((PipeStall_o || IDEX_Bubble_o) && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (IFID_Flush_o && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign StallCnt_o = r_stall_cnt;
  assign FlushCnt_o = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose  : self-checking bench for hazard_ctrl (directed scenarios plus randomized run vs. reference model).
// Latency  : controls checked on the negedge of the cycle they are driven; counters one edge later.
// Backpress: exercises memory freeze, pending flush and counter saturation (CNT_W = 4).
module tb_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             MemStall_i;
  logic             IDEX_MemRead_i;
  logic [4:0]       IDEX_Rd_i;
  logic [4:0]       IFID_Rs1_i;
  logic [4:0]       IFID_Rs2_i;
  logic             BranchTaken_i;
  logic             PCWrite_o;
  logic             IFID_Stall_o;
  logic             IFID_Flush_o;
  logic             IDEX_Bubble_o;
  logic             PipeStall_o;
  logic [CNT_W-1:0] StallCnt_o;
  logic [CNT_W-1:0] FlushCnt_o;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .MemStall_i     (MemStall_i),
    .IDEX_MemRead_i (IDEX_MemRead_i),
    .IDEX_Rd_i      (IDEX_Rd_i),
    .IFID_Rs1_i     (IFID_Rs1_i),
    .IFID_Rs2_i     (IFID_Rs2_i),
    .BranchTaken_i  (BranchTaken_i),
    .PCWrite_o      (PCWrite_o),
    .IFID_Stall_o   (IFID_Stall_o),
    .IFID_Flush_o   (IFID_Flush_o),
    .IDEX_Bubble_o  (IDEX_Bubble_o),
    .PipeStall_o    (PipeStall_o),
    .StallCnt_o     (StallCnt_o),
    .FlushCnt_o     (FlushCnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Control vector order: {PCWrite, IFID_Stall, IFID_Flush, IDEX_Bubble, PipeStall}
  logic [4:0] ctl;
  assign ctl = {PCWrite_o, IFID_Stall_o, IFID_Flush_o, IDEX_Bubble_o, PipeStall_o};

  localparam logic [4:0] C_IDLE   = 5'b00000;
  localparam logic [4:0] C_RUN    = 5'b10000;
  localparam logic [4:0] C_FREEZE = 5'b01001;
  localparam logic [4:0] C_LU     = 5'b01010;
  localparam logic [4:0] C_FLUSH  = 5'b10100;

  int nvec = 0;
  int nerr = 0;

  // Reference model: one "owed flush" flag plus plain saturating counts.
  bit         m_pend;
  logic [CNT_W-1:0] m_stall;
  logic [CNT_W-1:0] m_flush;
  logic [4:0] e_ctl;
  bit         m_lu;

  task automatic drive(input bit ms, input bit mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input bit br);
    MemStall_i     = ms;
    IDEX_MemRead_i = mr;
    IDEX_Rd_i      = rd;
    IFID_Rs1_i     = rs1;
    IFID_Rs2_i     = rs2;
    BranchTaken_i  = br;
  endtask

  // Wait to mid-cycle and compute the expected controls for the applied inputs.
  task automatic settle();
    bit reads_rd;
    @(negedge clk_i);
    reads_rd = (IDEX_Rd_i == IFID_Rs1_i) || (IDEX_Rd_i == IFID_Rs2_i);
    m_lu = IDEX_MemRead_i && (IDEX_Rd_i != 0) && reads_rd;
    if (rst_i)                        e_ctl = C_IDLE;
    else if (MemStall_i)              e_ctl = C_FREEZE;
    else if (m_lu)                    e_ctl = C_LU;
    else if (BranchTaken_i || m_pend) e_ctl = C_FLUSH;
    else                              e_ctl = C_RUN;
  endtask

  // Advance one clock and update the model's bookkeeping.
  task automatic commit();
    if (rst_i) begin
      m_pend  = 0;
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (MemStall_i) m_pend = m_pend | BranchTaken_i;
      if (e_ctl == C_FLUSH) begin
        m_pend = 0;
        if (m_flush != CMAX) m_flush = m_flush + 1'b1;
      end
      if ((e_ctl == C_FREEZE || e_ctl == C_LU) && m_stall != CMAX) m_stall = m_stall + 1'b1;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    settle();
    commit();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive(1, 1, 5'd3, 5'd3, 5'd0, 1);
    settle();
    nvec++;
    if (ctl !== C_IDLE) begin
      nerr++; $display("FAIL reset_ctl: got %b want %b", ctl, C_IDLE);
    end
    commit();
    nvec++;
    if (StallCnt_o !== 0 || FlushCnt_o !== 0) begin
      nerr++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", StallCnt_o, FlushCnt_o);
    end
    rst_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    settle();
    nvec++;
    if (ctl !== C_RUN) begin
      nerr++; $display("FAIL reset_run: got %b want %b", ctl, C_RUN);
    end
    commit();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(0, 1, 5'd5, 5'd3, 5'd5, 0);
    settle();
    nvec++;
    if (ctl !== C_LU) begin
      nerr++; $display("FAIL lu_ctl: got %b want %b", ctl, C_LU);
    end
    commit();
    nvec++;
    if (StallCnt_o !== 4'd1) begin
      nerr++; $display("FAIL lu_cnt: got %0d want 1", StallCnt_o);
    end
    drive(0, 1, 5'd0, 5'd0, 5'd0, 0);
    settle();
    nvec++;
    if (ctl !== C_RUN) begin
      nerr++; $display("FAIL lu_x0: got %b want %b", ctl, C_RUN);
    end
    commit();
    nvec++;
    if (StallCnt_o !== 4'd1) begin
      nerr++; $display("FAIL lu_x0_cnt: got %0d want 1", StallCnt_o);
    end
  endtask

  task automatic test_branch();
    do_reset();
    drive(0, 0, 0, 5'd1, 5'd2, 1);
    settle();
    nvec++;
    if (ctl !== C_FLUSH) begin
      nerr++; $display("FAIL br_ctl: got %b want %b", ctl, C_FLUSH);
    end
    commit();
    nvec++;
    if (FlushCnt_o !== 4'd1) begin
      nerr++; $display("FAIL br_cnt: got %0d want 1", FlushCnt_o);
    end
    drive(0, 0, 0, 0, 0, 0);
    settle();
    nvec++;
    if (ctl !== C_RUN) begin
      nerr++; $display("FAIL br_after: got %b want %b", ctl, C_RUN);
    end
    commit();
  endtask

  task automatic test_branch_in_mstall();
    int nfl = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 0, i == 1);
      settle();
      nvec++;
      if (ctl !== C_FREEZE) begin
        nerr++; $display("FAIL mst_freeze%0d: got %b want %b", i, ctl, C_FREEZE);
      end
      commit();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      settle();
      if (IFID_Flush_o === 1'b1) nfl++;
      if (i == 0) begin
        nvec++;
        if (ctl !== C_FLUSH) begin
          nerr++; $display("FAIL mst_release: got %b want %b", ctl, C_FLUSH);
        end
      end
      commit();
    end
    nvec++;
    if (nfl != 1) begin
      nerr++; $display("FAIL mst_once: got %0d flushes want 1", nfl);
    end
    nvec++;
    if (StallCnt_o !== 4'd4 || FlushCnt_o !== 4'd1) begin
      nerr++; $display("FAIL mst_cnt: got %0d/%0d want 4/1", StallCnt_o, FlushCnt_o);
    end
  endtask

  task automatic test_lu_branch();
    do_reset();
    drive(0, 1, 5'd7, 5'd7, 5'd9, 1);
    settle();
    nvec++;
    if (ctl !== C_LU) begin
      nerr++; $display("FAIL lubr_ctl: got %b want %b", ctl, C_LU);
    end
    commit();
    nvec++;
    if (FlushCnt_o !== 4'd0 || StallCnt_o !== 4'd1) begin
      nerr++; $display("FAIL lubr_cnt: got %0d/%0d want 1/0", StallCnt_o, FlushCnt_o);
    end
    drive(0, 0, 0, 0, 0, 0);
    settle();
    nvec++;
    if (ctl !== C_RUN) begin
      nerr++; $display("FAIL lubr_after: got %b want %b", ctl, C_RUN);
    end
    commit();
  endtask

  // Held branch across a freeze and its release: one flush only.
  task automatic test_back_to_back();
    do_reset();
    drive(1, 0, 0, 0, 0, 1); settle(); commit();
    drive(1, 0, 0, 0, 0, 1); settle(); commit();
    drive(0, 0, 0, 0, 0, 1);
    settle();
    nvec++;
    if (ctl !== C_FLUSH) begin
      nerr++; $display("FAIL b2b_flush: got %b want %b", ctl, C_FLUSH);
    end
    commit();
    drive(0, 0, 0, 0, 0, 0);
    settle();
    nvec++;
    if (ctl !== C_RUN) begin
      nerr++; $display("FAIL b2b_noflush: got %b want %b", ctl, C_RUN);
    end
    commit();
    nvec++;
    if (FlushCnt_o !== 4'd1) begin
      nerr++; $display("FAIL b2b_cnt: got %0d want 1", FlushCnt_o);
    end
    // Memory stall beats load-use; load-use reappears on release.
    drive(1, 1, 5'd4, 5'd4, 5'd0, 0);
    settle();
    nvec++;
    if (ctl !== C_FREEZE) begin
      nerr++; $display("FAIL memlu_freeze: got %b want %b", ctl, C_FREEZE);
    end
    commit();
    drive(0, 1, 5'd4, 5'd4, 5'd0, 0);
    settle();
    nvec++;
    if (ctl !== C_LU) begin
      nerr++; $display("FAIL memlu_release: got %b want %b", ctl, C_LU);
    end
    commit();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1, 0, 0, 0, 0, 1); settle(); commit();
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0); settle(); commit();
    rst_i = 1'b0;
    settle();
    nvec++;
    if (ctl !== C_RUN) begin
      nerr++; $display("FAIL rms_noflush: got %b want %b", ctl, C_RUN);
    end
    commit();
    nvec++;
    if (StallCnt_o !== 0 || FlushCnt_o !== 0) begin
      nerr++; $display("FAIL rms_cnt: got %0d/%0d want 0/0", StallCnt_o, FlushCnt_o);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0, 0, 0); settle(); commit();
      if (i == 14) begin
        nvec++;
        if (StallCnt_o !== 4'd15) begin
          nerr++; $display("FAIL sat_reach: got %0d want 15", StallCnt_o);
        end
      end
    end
    nvec++;
    if (StallCnt_o !== 4'd15) begin
      nerr++; $display("FAIL sat_hold: got %0d want 15", StallCnt_o);
    end
    drive(0, 0, 0, 0, 0, 0); settle(); commit();
  endtask

  task automatic test_random();
    logic [4:0] rd, rs1, rs2;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst_i = ($urandom_range(0, 49) == 0);
      rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, rd, rs1, rs2,
            $urandom_range(0, 3) == 0);
      settle();
      nvec++;
      if (ctl !== e_ctl) begin
        nerr++; $display("FAIL rnd_ctl[%0d]: got %b want %b", i, ctl, e_ctl);
      end
      commit();
      nvec++;
      if (StallCnt_o !== m_stall || FlushCnt_o !== m_flush) begin
        nerr++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d",
                         i, StallCnt_o, FlushCnt_o, m_stall, m_flush);
      end
    end
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    m_pend  = 0;
    m_stall = '0;
    m_flush = '0;
    m_lu    = 0;
    e_ctl   = C_IDLE;
    test_reset();
    test_load_use();
    test_branch();
    test_branch_in_mstall();
    test_lu_branch();
    test_back_to_back();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core. Drives the Stall/Flush controls of the IF/ID register, PC write enable, ID/EX bubble insertion and the global memory-stall freeze.
- Resolves, in priority order: data-cache busy stall, load-use hazard, taken-branch flush.
- Keeps a pending-flush flag so a flush is not lost while the pipe is frozen.
- Keeps saturating stall/flush event counters for performance debug.

Parameters:
- CNT_W, 16, width of the stall-cycle and flush-event counters.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous reset, active-high
- MemStall_i  in  1  data cache busy; whole pipe must freeze while high
- IDEX_MemRead_i  in  1  instruction in EX is a load
- IDEX_Rd_i  in  5  destination register of instruction in EX
- IFID_Rs1_i  in  5  rs1 field of instruction in ID
- IFID_Rs2_i  in  5  rs2 field of instruction in ID
- BranchTaken_i  in  1  branch in ID resolved taken this cycle
- PCWrite_o  out  1  PC update enable
- IFID_Stall_o  out  1  hold IF/ID contents
- IFID_Flush_o  out  1  clear IF/ID to zero (NOP)
- IDEX_Bubble_o  out  1  force ID/EX control fields to zero
- PipeStall_o  out  1  freeze ID/EX, EX/MEM, MEM/WB
- StallCnt_o  out  CNT_W  count of stall cycles (memory + load-use)
- FlushCnt_o  out  CNT_W  count of flushes issued

Behaviour:
- Reset: rst_i sampled at posedge clk_i.
  - Clears state to RUN, flush_pend to 0, StallCnt_o and FlushCnt_o to 0.
  - While rst_i is high, all combinational outputs are forced to: PCWrite_o=0, IFID_Stall_o=0, IFID_Flush_o=0, IDEX_Bubble_o=0, PipeStall_o=0.
  - Reset mid-stall or with a pending flush discards both.
- Hazard term: lu = IDEX_MemRead_i & (IDEX_Rd_i!=0) & ((IDEX_Rd_i==IFID_Rs1_i) | (IDEX_Rd_i==IFID_Rs2_i)). x0 never causes a hazard.
- Control outputs are combinational from state, flush_pend and the current inputs, so they take effect at the same edge (zero latency). State, flush_pend and counters are registered.
- FSM state RUN:
  - MemStall_i=1: PipeStall_o=1, IFID_Stall_o=1, PCWrite_o=0, IFID_Flush_o=0, IDEX_Bubble_o=0. If BranchTaken_i=1, set flush_pend. Next state MSTALL.
  - Else if lu=1: PCWrite_o=0, IFID_Stall_o=1, IDEX_Bubble_o=1, IFID_Flush_o=0. BranchTaken_i is ignored (its operands are stale). Stays RUN.
  - Else if BranchTaken_i or flush_pend: IFID_Flush_o=1, PCWrite_o=1. Clear flush_pend, FlushCnt +1. Stays RUN.
  - Else: PCWrite_o=1, all other controls 0.
- FSM state MSTALL:
  - MemStall_i=1: same freeze outputs as above. flush_pend |= BranchTaken_i. Stays MSTALL.
  - MemStall_i=0: evaluated exactly as RUN without the MemStall branch (load-use, then flush with pending honoured). Next state RUN.
- Exactly one flush per taken branch: flush_pend is cleared on the cycle IFID_Flush_o asserts. A held BranchTaken_i plus flush_pend yields one flush, not two.
- IFID_Flush_o and IFID_Stall_o are never both 1. PipeStall_o=1 implies IFID_Flush_o=0 and IDEX_Bubble_o=0.
- StallCnt_o: +1 in every non-reset cycle where PipeStall_o | IDEX_Bubble_o. Saturates at all-ones.
- FlushCnt_o: +1 per cycle with IFID_Flush_o=1. Saturates at all-ones.
- Simultaneous MemStall_i and lu: memory stall wins, no bubble. lu is re-evaluated on the release cycle.

Test Plan:
- Load-use: IDEX_MemRead_i=1, IDEX_Rd_i=5, IFID_Rs2_i=5 for one cycle -> PCWrite_o=0, IFID_Stall_o=1, IDEX_Bubble_o=1 that cycle; StallCnt_o=1 next cycle. Same stimulus with IDEX_Rd_i=0 -> no stall.
- Taken branch: BranchTaken_i=1 one cycle, no hazards -> IFID_Flush_o=1, PCWrite_o=1; FlushCnt_o=1 next cycle.
- Branch during memory stall: MemStall_i high 4 cycles, BranchTaken_i pulsed in cycle 2 only -> PipeStall_o=1 for 4 cycles, no flush during them. IFID_Flush_o=1 on the first cycle MemStall_i=0, exactly once. StallCnt_o=4, FlushCnt_o=1.
- Load-use plus branch in the same cycle (Rd==Rs1, BranchTaken_i=1) -> bubble and stall only, IFID_Flush_o=0, FlushCnt_o unchanged.
- Reset mid-stall: MemStall_i=1 with a branch to set flush_pend, then rst_i=1 one cycle, then MemStall_i=0 and BranchTaken_i=0 -> no flush issued; counters read 0.
- Saturation with CNT_W=4: hold MemStall_i 20 cycles -> StallCnt_o stops at 15.
